// File: rtl/wb_burst_master_if.sv
// Bundle of the burst master's command, write/read streams, Wishbone bus and status.
// master = the burst master's view, slave = the surrounding engine/interconnect view.
interface wb_burst_master_if #(
  parameter int Dw   = 32,
  parameter int Aw   = 10,
  parameter int LENw = 8,
  parameter int SELw = Dw/8,
  parameter int CTIw = 3,
  parameter int BTEw = 2
);
  logic            cmd_valid, cmd_ready, cmd_we;
  logic [Aw-1:0]   cmd_addr;
  logic [LENw-1:0] cmd_len;
  logic [Dw-1:0]   wr_dat_i;
  logic            wr_valid, wr_ready;
  logic [Dw-1:0]   rd_dat_o;
  logic            rd_valid, rd_ready;
  logic [Dw-1:0]   m_dat_o, m_dat_i;
  logic [SELw-1:0] m_sel_o;
  logic [Aw-1:0]   m_addr_o;
  logic [CTIw-1:0] m_cti_o;
  logic [BTEw-1:0] m_bte_o;
  logic            m_stb_o, m_cyc_o, m_we_o;
  logic            m_ack_i, m_err_i, m_rty_i;
  logic            busy, done, error;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_dat_i, wr_valid, rd_ready,
           m_dat_i, m_ack_i, m_err_i, m_rty_i,
    output cmd_ready, wr_ready, rd_dat_o, rd_valid, m_dat_o, m_sel_o, m_addr_o,
           m_cti_o, m_bte_o, m_stb_o, m_cyc_o, m_we_o, busy, done, error
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_dat_i, wr_valid, rd_ready,
           m_dat_i, m_ack_i, m_err_i, m_rty_i,
    input  cmd_ready, wr_ready, rd_dat_o, rd_valid, m_dat_o, m_sel_o, m_addr_o,
           m_cti_o, m_bte_o, m_stb_o, m_cyc_o, m_we_o, busy, done, error
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: one command of 1..2^LENw-1 word beats, streamed write/read data.
// Optional watchdog abort on a silent slave is enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_burst_master #(
  parameter int Dw             = 32,
  parameter int Aw             = 10,
  parameter int LENw           = 8,
  parameter int SELw           = Dw/8,
  parameter int CTIw           = 3,
  parameter int BTEw           = 2,
  parameter     BURST_MODE     = "ENABLED",
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               reset,
  wb_burst_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
  localparam bit BURST = (BURST_MODE == "ENABLED");

  state_t          state, state_nxt;
  logic            cyc_r, we_r, rty_hold, rd_valid_r, done_r, error_r;
  logic [Aw-1:0]   addr_r;
  logic [LENw-1:0] rem_r;
  logic [Dw-1:0]   rd_dat_r;
  logic            stb, resp, ack_ok, err_ok, rty_ok, timeout, abort;

  // Reads only strobe when the output register is free or being drained this cycle.
  always_comb begin
    stb = 1'b0;
    if (cyc_r && !rty_hold)
      stb = we_r ? bus.wr_valid : (!rd_valid_r || bus.rd_ready);
  end

  // Response priority: err over ack over rty.
  assign err_ok = stb & bus.m_err_i;
  assign ack_ok = stb & bus.m_ack_i & ~bus.m_err_i;
  assign rty_ok = stb & bus.m_rty_i & ~bus.m_ack_i & ~bus.m_err_i;
  assign resp   = stb & (bus.m_ack_i | bus.m_err_i | bus.m_rty_i);

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TOw = $clog2(TIMEOUT_CYCLES + 1);
  logic [TOw-1:0] to_cnt;

  // Abort on the TIMEOUT_CYCLES-th consecutive unanswered strobe cycle.
  assign timeout = stb & ~resp & (to_cnt == TOw'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              to_cnt <= '0;
    else if (!stb || resp)  to_cnt <= '0;
    else                    to_cnt <= to_cnt + TOw'(1);
  end
`else
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  assign abort = err_ok | timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (bus.cmd_valid && bus.cmd_len != '0)
          state_nxt = (bus.cmd_len == LENw'(1)) ? LAST : RUN;
      RUN:
        if (abort)                              state_nxt = IDLE;
        else if (ack_ok && rem_r == LENw'(2))   state_nxt = LAST;
      LAST:
        if (abort || ack_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_r      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      rem_r      <= '0;
      rty_hold   <= 1'b0;
      rd_dat_r   <= '0;
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      cyc_r    <= (state_nxt != IDLE);
      rty_hold <= rty_ok;
      done_r   <= 1'b0;
      if (state == IDLE) begin
        if (bus.cmd_valid) begin
          we_r    <= bus.cmd_we;
          addr_r  <= bus.cmd_addr;
          rem_r   <= bus.cmd_len;
          error_r <= 1'b0;
          if (bus.cmd_len == '0) done_r <= 1'b1;
        end
      end else if (abort) begin
        error_r <= 1'b1;
        done_r  <= 1'b1;
      end else if (ack_ok) begin
        addr_r <= addr_r + Aw'(1);
        rem_r  <= rem_r - LENw'(1);
        if (state == LAST) done_r <= 1'b1;
      end
      // A same-cycle drain and new beat simply reloads the register.
      if (ack_ok && !we_r) begin
        rd_dat_r   <= bus.m_dat_i;
        rd_valid_r <= 1'b1;
      end else if (bus.rd_ready) begin
        rd_valid_r <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.error     = error_r;
  assign bus.wr_ready  = ack_ok & we_r;
  assign bus.rd_dat_o  = rd_dat_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.m_dat_o   = (cyc_r && we_r) ? bus.wr_dat_i : '0;
  assign bus.m_sel_o   = {SELw{cyc_r}};
  assign bus.m_addr_o  = addr_r;
  assign bus.m_bte_o   = '0;
  assign bus.m_stb_o   = stb;
  assign bus.m_cyc_o   = cyc_r;
  assign bus.m_we_o    = cyc_r & we_r;
  assign bus.m_cti_o   = (!BURST || state == IDLE) ? CTIw'(0) :
                         (state == LAST)           ? CTIw'(3'b111) : CTIw'(3'b010);
endmodule
